// File: rtl/td4x_cpu_if.sv
// Control, program-load and debug signals of the td4x_cpu core.
// The board/bench side uses the master modport; the core uses the slave modport.
interface td4x_cpu_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
);
    logic              run;
    logic              step;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W+3:0] prog_data;
    logic [DATA_W-1:0] sw;
    logic [DATA_W-1:0] LED;
    logic [ADDR_W-1:0] pc;
    logic              carry;

    modport master (
        output run, step, prog_we, prog_addr, prog_data, sw,
        input  LED, pc, carry
    );

    modport slave (
        input  run, step, prog_we, prog_addr, prog_data, sw,
        output LED, pc, carry
    );
endinterface

// File: rtl/td4x_cpu.sv
// Parametrised TD4-style accumulator CPU with writable program memory,
// run/halt/single-step control and an execution-rate prescaler.
module td4x_cpu #(
    parameter int DATA_W  = 4,
    parameter int ADDR_W  = 4,
    parameter int CLK_DIV = 1
) (
    input  logic        clock,
    input  logic        reset,
    td4x_cpu_if.slave   bus
);
    localparam int INSTR_W = DATA_W + 4;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        OP_ADD_A  = 4'b0000,
        OP_MOV_AB = 4'b0001,
        OP_IN_A   = 4'b0010,
        OP_MOV_AI = 4'b0011,
        OP_MOV_BA = 4'b0100,
        OP_ADD_B  = 4'b0101,
        OP_IN_B   = 4'b0110,
        OP_MOV_BI = 4'b0111,
        OP_OUT_B  = 4'b1001,
        OP_OUT_I  = 4'b1011,
        OP_JNC    = 4'b1110,
        OP_JMP    = 4'b1111
    } opcode_e;

    logic [INSTR_W-1:0] mem_q [DEPTH];

    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [DATA_W-1:0]  out_q, out_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               tick;
    logic               exec;
    logic [INSTR_W-1:0] instr;
    opcode_e            op;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  add_src;
    logic [DATA_W:0]    sum;

    // The prescaler only advances while running; halting discards any partial count.
    assign tick  = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign exec  = bus.run ? tick : bus.step;

    assign instr   = mem_q[pc_q];
    assign op      = opcode_e'(instr[INSTR_W-1:DATA_W]);
    assign imm     = instr[DATA_W-1:0];
    assign add_src = (op == OP_ADD_B) ? b_q : a_q;
    assign sum     = {1'b0, add_src} + {1'b0, imm};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = '0;
        if (bus.run && !tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        pc_d    = pc_q;
        carry_d = carry_q;
        if (exec) begin
            pc_d    = pc_q + ADDR_W'(1);
            carry_d = 1'b0;
            case (op)
                OP_ADD_A:  begin a_d = sum[DATA_W-1:0]; carry_d = sum[DATA_W]; end
                OP_MOV_AB: a_d = b_q;
                OP_IN_A:   a_d = bus.sw;
                OP_MOV_AI: a_d = imm;
                OP_MOV_BA: b_d = a_q;
                OP_ADD_B:  begin b_d = sum[DATA_W-1:0]; carry_d = sum[DATA_W]; end
                OP_IN_B:   b_d = bus.sw;
                OP_MOV_BI: b_d = imm;
                OP_OUT_B:  out_d = b_q;
                OP_OUT_I:  out_d = imm;
                OP_JNC:    if (!carry_q) pc_d = imm[ADDR_W-1:0];
                OP_JMP:    pc_d = imm[ADDR_W-1:0];
                default:   ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            pc_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            pc_q    <= pc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: program memory has no reset so the program survives a core reset and maps to RAM.
    always_ff @(posedge clock) begin
        if (!reset && bus.prog_we && !bus.run) begin
            mem_q[bus.prog_addr] <= bus.prog_data;
        end
    end

    assign bus.LED   = out_q;
    assign bus.pc    = pc_q;
    assign bus.carry = carry_q;
endmodule

// File: tb/tb_td4x_cpu.sv
// Directed bench for td4x_cpu: three instances cover the default core,
// a CLK_DIV=4 prescaled core and an 8-bit data / 6-bit address core.
module tb_td4x_cpu;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    td4x_cpu_if #(.DATA_W(4), .ADDR_W(4)) bus_a ();
    td4x_cpu_if #(.DATA_W(4), .ADDR_W(4)) bus_b ();
    td4x_cpu_if #(.DATA_W(8), .ADDR_W(6)) bus_c ();

    td4x_cpu #(.DATA_W(4), .ADDR_W(4), .CLK_DIV(1)) dut_a (.clock(clock), .reset(reset), .bus(bus_a));
    td4x_cpu #(.DATA_W(4), .ADDR_W(4), .CLK_DIV(4)) dut_b (.clock(clock), .reset(reset), .bus(bus_b));
    td4x_cpu #(.DATA_W(8), .ADDR_W(6), .CLK_DIV(1)) dut_c (.clock(clock), .reset(reset), .bus(bus_c));

    // MOV A,5; ADD A,12; JNC 0; MOV B,A; OUT B; JMP 5
    logic [7:0] prog1 [6] = '{8'b0011_0101, 8'b0000_1100, 8'b1110_0000,
                              8'b0100_0000, 8'b1001_0000, 8'b1111_0101};

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wr_a(input logic [3:0] addr, input logic [7:0] data);
        bus_a.prog_addr = addr; bus_a.prog_data = data; bus_a.prog_we = 1'b1;
        @(negedge clock);
        bus_a.prog_we = 1'b0;
    endtask

    task automatic wr_b(input logic [3:0] addr, input logic [7:0] data);
        bus_b.prog_addr = addr; bus_b.prog_data = data; bus_b.prog_we = 1'b1;
        @(negedge clock);
        bus_b.prog_we = 1'b0;
    endtask

    task automatic wr_c(input logic [5:0] addr, input logic [11:0] data);
        bus_c.prog_addr = addr; bus_c.prog_data = data; bus_c.prog_we = 1'b1;
        @(negedge clock);
        bus_c.prog_we = 1'b0;
    endtask

    task automatic step_a();
        bus_a.step = 1'b1;
        @(negedge clock);
        bus_a.step = 1'b0;
    endtask

    task automatic step_c();
        bus_c.step = 1'b1;
        @(negedge clock);
        bus_c.step = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        if (bus_a.pc !== 4'd0) begin n_err++; $display("FAIL reset_pc_a: got %0d want 0", bus_a.pc); end n_cmp++;
        if (bus_a.LED !== 4'd0) begin n_err++; $display("FAIL reset_led_a: got %0d want 0", bus_a.LED); end n_cmp++;
        if (bus_a.carry !== 1'b0) begin n_err++; $display("FAIL reset_carry_a: got %0b want 0", bus_a.carry); end n_cmp++;
        if (bus_b.pc !== 4'd0) begin n_err++; $display("FAIL reset_pc_b: got %0d want 0", bus_b.pc); end n_cmp++;
        if (bus_c.pc !== 6'd0) begin n_err++; $display("FAIL reset_pc_c: got %0d want 0", bus_c.pc); end n_cmp++;
        if (bus_c.LED !== 8'd0) begin n_err++; $display("FAIL reset_led_c: got %0h want 0", bus_c.LED); end n_cmp++;
    endtask

    task automatic test_program();
        for (int i = 0; i < 6; i++) wr_a(4'(i), prog1[i]);
        do_reset();
        bus_a.run = 1'b1;
        @(negedge clock);
        if (bus_a.pc !== 4'd1) begin n_err++; $display("FAIL prog_mov_pc: got %0d want 1", bus_a.pc); end n_cmp++;
        @(negedge clock);
        if (bus_a.carry !== 1'b1) begin n_err++; $display("FAIL prog_add_carry: got %0b want 1", bus_a.carry); end n_cmp++;
        if (bus_a.pc !== 4'd2) begin n_err++; $display("FAIL prog_add_pc: got %0d want 2", bus_a.pc); end n_cmp++;
        @(negedge clock);
        if (bus_a.pc !== 4'd3) begin n_err++; $display("FAIL prog_jnc_not_taken: got %0d want 3", bus_a.pc); end n_cmp++;
        if (bus_a.carry !== 1'b0) begin n_err++; $display("FAIL prog_jnc_carry: got %0b want 0", bus_a.carry); end n_cmp++;
        repeat (2) @(negedge clock);
        if (bus_a.LED !== 4'd1) begin n_err++; $display("FAIL prog_led: got %0d want 1", bus_a.LED); end n_cmp++;
        if (bus_a.pc !== 4'd5) begin n_err++; $display("FAIL prog_pc5: got %0d want 5", bus_a.pc); end n_cmp++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (bus_a.pc !== 4'd5) begin n_err++; $display("FAIL prog_jmp_loop: got %0d want 5", bus_a.pc); end n_cmp++;
        end
        bus_a.run = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) wr_a(4'(i), 8'h00);
        do_reset();
        bus_a.run = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clock);
            if (bus_a.pc !== 4'(i % 16)) begin n_err++; $display("FAIL wrap_pc: got %0d want %0d", bus_a.pc, i % 16); end n_cmp++;
            if (bus_a.carry !== 1'b0) begin n_err++; $display("FAIL wrap_carry: got %0b want 0", bus_a.carry); end n_cmp++;
        end
        bus_a.run = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_prescale();
        wr_b(4'd0, 8'hB1); wr_b(4'd1, 8'hB2); wr_b(4'd2, 8'hB3);
        wr_b(4'd3, 8'h00); wr_b(4'd4, 8'h00); wr_b(4'd5, 8'h00);
        do_reset();
        bus_b.run = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (bus_b.LED !== 4'(c / 4)) begin n_err++; $display("FAIL div_led c=%0d: got %0d want %0d", c, bus_b.LED, c / 4); end n_cmp++;
            if (bus_b.pc !== 4'(c / 4)) begin n_err++; $display("FAIL div_pc c=%0d: got %0d want %0d", c, bus_b.pc, c / 4); end n_cmp++;
        end
        repeat (2) @(negedge clock);
        bus_b.run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (bus_b.pc !== 4'd3) begin n_err++; $display("FAIL div_halt_pc: got %0d want 3", bus_b.pc); end n_cmp++;
        end
        bus_b.run = 1'b1;
        repeat (3) @(negedge clock);
        if (bus_b.pc !== 4'd3) begin n_err++; $display("FAIL div_rerun_early: got %0d want 3", bus_b.pc); end n_cmp++;
        @(negedge clock);
        if (bus_b.pc !== 4'd4) begin n_err++; $display("FAIL div_rerun_full: got %0d want 4", bus_b.pc); end n_cmp++;
        bus_b.run = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_step();
        wr_a(4'd0, 8'h20); wr_a(4'd1, 8'h40); wr_a(4'd2, 8'h90);
        bus_a.sw = 4'd9;
        do_reset();
        step_a();
        if (bus_a.pc !== 4'd1) begin n_err++; $display("FAIL step1_pc: got %0d want 1", bus_a.pc); end n_cmp++;
        repeat (3) @(negedge clock);
        if (bus_a.pc !== 4'd1) begin n_err++; $display("FAIL step_idle_pc: got %0d want 1", bus_a.pc); end n_cmp++;
        step_a();
        if (bus_a.pc !== 4'd2) begin n_err++; $display("FAIL step2_pc: got %0d want 2", bus_a.pc); end n_cmp++;
        if (bus_a.LED !== 4'd0) begin n_err++; $display("FAIL step2_led: got %0d want 0", bus_a.LED); end n_cmp++;
        step_a();
        if (bus_a.pc !== 4'd3) begin n_err++; $display("FAIL step3_pc: got %0d want 3", bus_a.pc); end n_cmp++;
        if (bus_a.LED !== 4'd9) begin n_err++; $display("FAIL step3_led: got %0d want 9", bus_a.LED); end n_cmp++;
        // write OUT 5 to word 0 in the same cycle as a step: the old IN A executes
        do_reset();
        bus_a.prog_addr = 4'd0; bus_a.prog_data = 8'hB5; bus_a.prog_we = 1'b1; bus_a.step = 1'b1;
        @(negedge clock);
        bus_a.prog_we = 1'b0; bus_a.step = 1'b0;
        if (bus_a.LED !== 4'd0) begin n_err++; $display("FAIL rbw_old_word: got %0d want 0", bus_a.LED); end n_cmp++;
        do_reset();
        step_a();
        if (bus_a.LED !== 4'd5) begin n_err++; $display("FAIL rbw_new_word: got %0d want 5", bus_a.LED); end n_cmp++;
        // a write while running must be dropped
        do_reset();
        bus_a.run = 1'b1;
        bus_a.prog_addr = 4'd0; bus_a.prog_data = 8'hB7; bus_a.prog_we = 1'b1;
        @(negedge clock);
        bus_a.prog_we = 1'b0; bus_a.run = 1'b0;
        do_reset();
        step_a();
        if (bus_a.LED !== 4'd5) begin n_err++; $display("FAIL run_write_ignored: got %0d want 5", bus_a.LED); end n_cmp++;
    endtask

    task automatic test_wide();
        wr_c(6'd0, 12'h3F0); wr_c(6'd1, 12'h020); wr_c(6'd2, 12'h400);
        wr_c(6'd3, 12'h900); wr_c(6'd4, 12'hF7F);
        do_reset();
        step_c();
        if (bus_c.pc !== 6'd1) begin n_err++; $display("FAIL wide_pc1: got %0d want 1", bus_c.pc); end n_cmp++;
        step_c();
        if (bus_c.carry !== 1'b1) begin n_err++; $display("FAIL wide_add_carry: got %0b want 1", bus_c.carry); end n_cmp++;
        step_c();
        if (bus_c.carry !== 1'b0) begin n_err++; $display("FAIL wide_mov_carry: got %0b want 0", bus_c.carry); end n_cmp++;
        step_c();
        if (bus_c.LED !== 8'h10) begin n_err++; $display("FAIL wide_led: got %0h want 10", bus_c.LED); end n_cmp++;
        step_c();
        if (bus_c.pc !== 6'h3F) begin n_err++; $display("FAIL wide_jmp_pc: got %0h want 3f", bus_c.pc); end n_cmp++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) wr_a(4'(i), prog1[i]);
        do_reset();
        bus_a.run = 1'b1;
        repeat (3) @(negedge clock);
        if (bus_a.pc !== 4'd3) begin n_err++; $display("FAIL mid_pc3: got %0d want 3", bus_a.pc); end n_cmp++;
        reset = 1'b1;
        @(negedge clock);
        if (bus_a.pc !== 4'd0) begin n_err++; $display("FAIL mid_reset_pc: got %0d want 0", bus_a.pc); end n_cmp++;
        if (bus_a.LED !== 4'd0) begin n_err++; $display("FAIL mid_reset_led: got %0d want 0", bus_a.LED); end n_cmp++;
        if (bus_a.carry !== 1'b0) begin n_err++; $display("FAIL mid_reset_carry: got %0b want 0", bus_a.carry); end n_cmp++;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        if (bus_a.pc !== 4'd2) begin n_err++; $display("FAIL mid_resume_pc: got %0d want 2", bus_a.pc); end n_cmp++;
        if (bus_a.carry !== 1'b1) begin n_err++; $display("FAIL mid_resume_carry: got %0b want 1", bus_a.carry); end n_cmp++;
        repeat (3) @(negedge clock);
        if (bus_a.LED !== 4'd1) begin n_err++; $display("FAIL mid_resume_led: got %0d want 1", bus_a.LED); end n_cmp++;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        bus_a.run = 1'b0;
        if (bus_a.LED !== 4'd0) begin n_err++; $display("FAIL mid_reset_led2: got %0d want 0", bus_a.LED); end n_cmp++;
        if (bus_a.pc !== 4'd0) begin n_err++; $display("FAIL mid_reset_pc2: got %0d want 0", bus_a.pc); end n_cmp++;
    endtask

    initial begin
        bus_a.run = 1'b0; bus_a.step = 1'b0; bus_a.prog_we = 1'b0;
        bus_a.prog_addr = '0; bus_a.prog_data = '0; bus_a.sw = '0;
        bus_b.run = 1'b0; bus_b.step = 1'b0; bus_b.prog_we = 1'b0;
        bus_b.prog_addr = '0; bus_b.prog_data = '0; bus_b.sw = '0;
        bus_c.run = 1'b0; bus_c.step = 1'b0; bus_c.prog_we = 1'b0;
        bus_c.prog_addr = '0; bus_c.prog_data = '0; bus_c.sw = '0;
        @(negedge clock);
        test_reset();
        test_program();
        test_wrap();
        test_prescale();
        test_step();
        test_wide();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/td4x_cpu.md
Name: td4x_cpu

Overview:
- Parametrised successor to the 4-bit TD4 core: same accumulator-style instruction set, with configurable data width and program depth.
- Adds three things the 4-bit core lacks: a writable internal program memory, run/halt/single-step control, and a built-in execution-rate prescaler.
- Sits under the board top: `sw` drives the input port, `LED` shows the output register, and `pc`/`carry` are exposed for debug.

Parameters:
- DATA_W, 4: width of registers A, B, OUT, the immediate field, `sw` and `LED`.
- ADDR_W, 4: PC width; program depth is 2^ADDR_W words. Must satisfy ADDR_W <= DATA_W.
- CLK_DIV, 1: clock cycles per executed instruction while running. Must be >= 1.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run  in  1  1 = free-run at the prescaled rate; 0 = halted
- step  in  1  one-cycle pulse; executes one instruction while halted
- prog_we  in  1  program-memory write strobe, honoured only while run=0
- prog_addr  in  ADDR_W  program-memory write address
- prog_data  in  4+DATA_W  instruction word: [DATA_W+3:DATA_W] = opcode, [DATA_W-1:0] = imm
- sw  in  DATA_W  input port
- LED  out  DATA_W  output register OUT
- pc  out  ADDR_W  current program counter
- carry  out  1  carry flag

Behaviour:
- One clock domain; reset is synchronous and active-high on `reset`. Reset has priority over every other input.
- Reset values: A=0, B=0, OUT/LED=0, PC=0, carry=0, prescaler=0.
- Program memory is not affected by reset. It is initialised to all-zero at configuration, which decodes as ADD A,0.
- Execute strobe: exec = run ? tick : step.
  - Prescaler counts 0..CLK_DIV-1 only while run=1.
  - tick=1 in the cycle the prescaler equals CLK_DIV-1; the prescaler then wraps to 0.
  - Prescaler is cleared while run=0.
  - With CLK_DIV=1, one instruction executes every cycle.
- `step` is ignored while run=1.
- Fetch is a combinational read of mem[PC]. All state updates at the clock edge where exec=1; there is no pipeline and latency is one instruction.
- Opcodes (imm = low DATA_W bits of the instruction word):
  - 0000 ADD A,imm: A = A + imm.
  - 0001 MOV A,B.
  - 0010 IN A: A = sw.
  - 0011 MOV A,imm.
  - 0100 MOV B,A.
  - 0101 ADD B,imm.
  - 0110 IN B.
  - 0111 MOV B,imm.
  - 1001 OUT B: OUT = B.
  - 1011 OUT imm.
  - 1110 JNC imm: jump if carry=0.
  - 1111 JMP imm.
  - All other opcodes are NOP.
- Adds are modulo 2^DATA_W. carry is loaded with the adder carry-out on ADD instructions and with 0 on every other executed instruction, including jumps and NOPs.
- JNC tests the carry produced by the previous executed instruction.
- PC update: PC+1 modulo 2^ADDR_W (0xF wraps to 0 for ADDR_W=4). A taken jump loads imm[ADDR_W-1:0].
- When exec=0, all architectural state holds.
- Program write: when prog_we=1 and run=0, mem[prog_addr] = prog_data at the clock edge. When run=1, prog_we is ignored.
- A write and a step in the same cycle both take effect; the executed instruction is the pre-write contents (read-before-write).
- Reset mid-program returns PC to 0 and clears registers. Memory contents are retained, so the program restarts from word 0.
- Dropping run mid-prescale discards the partial count; the next run starts a full CLK_DIV period.
- `sw` is sampled only at the executing edge.

Test Plan:
- Defaults, reset then load {0011_0101 MOV A,5; 0000_1100 ADD A,12; 1110_0000 JNC 0; 0100_0000 MOV B,A; 1001_0000 OUT B; 1111_0101 JMP 5}, run=1:
  - ADD gives A=1, carry=1.
  - JNC is not taken; carry then clears.
  - LED=1 after the 5th instruction.
  - PC then holds at 5 (JMP 5 loops on itself).
- Run a 16-word program of 0000_0000 with CLK_DIV=1 → pc steps 0..15 then wraps to 0. carry stays 0.
- CLK_DIV=4, program OUT imm values 1,2,3 in sequence → LED changes exactly every 4 clocks. Deassert run mid-count → pc freezes and does not advance for 10 cycles.
- Halted, step pulses one at a time on IN A (sw=9) then MOV B,A then OUT B → exactly one instruction per pulse; LED=9 after the 3rd pulse. A write to address 0 during run=1 is ignored (re-read confirms old word).
- DATA_W=8, ADDR_W=6 → MOV A,0xF0; ADD A,0x20 gives A=0x10, carry=1. JMP 0x7F loads PC=0x3F (low 6 bits of imm).
- Assert reset at pc=3 with run=1 → next cycle pc=0, LED=0, carry=0. Program memory unchanged, and execution resumes from word 0.
